alu_seq: RTL and testbench

//  Parametrised, registered ALU with a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_MUL  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_BZ   = 4'h7;
  localparam logic [3:0] ALU_SLTS = 4'h8;
  localparam logic [3:0] ALU_SHL  = 4'h9;
  localparam logic [3:0] ALU_SHR  = 4'hA;
  localparam logic [3:0] ALU_SRA  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between decode, the ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             neg;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, ans, zero, carry, ovf, neg, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, ans, zero, carry, ovf, neg, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock.
// The first step is folded into the start edge so the full product is ready
// WIDTH-1 edges later, with done high for exactly one cycle.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  // {high, low} accumulator: conditionally add multiplicand to high half, shift right.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                              input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, p[WIDTH-1:1]};
  endfunction

  // Load operands with first step applied, then count remaining steps down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= mcand;
      prod_q  <= step({{WIDTH{1'b0}}, mplier}, mcand);
      cnt_q   <= CNT_W'(WIDTH - 1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        prod_q <= step(prod_q, mcand_q);
        cnt_q  <= cnt_q - 1'b1;
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done    = busy_q && (cnt_q == '0);
  assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; MUL runs iteratively.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no result pending, ready for a new op
//  BUSY    | multiplier stepping, input side stalled
//  DONE    | result on ans/flags, held until out_ready
//
// SHAMT_W must equal $clog2(WIDTH); the shift amount is the low SHAMT_W bits of b.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  alu_state_e state, state_nxt;

  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   res;
  logic               res_carry;
  logic               res_ovf;
  logic               res_err;

  logic [WIDTH-1:0]   ans_q;
  logic               zero_q;
  logic               carry_q;
  logic               ovf_q;
  logic               neg_q;
  logic               err_q;

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_DONE && bus.out_ready);
  assign bus.out_valid = (state == ST_DONE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign is_mul        = (bus.op == ALU_MUL);
  assign mul_start     = accept && is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .mcand   (bus.a),
    .mplier  (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a new op may start from IDLE or straight out of DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done) state_nxt = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          if (accept) state_nxt = is_mul ? ST_BUSY : ST_DONE;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
  assign shamt = bus.b[SHAMT_W-1:0];

  // Single-cycle op datapath; MUL result comes from the iterative unit instead.
  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    res_err   = 1'b0;
    case (bus.op)
      ALU_ADD: begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SUB: begin
        res       = diff[WIDTH-1:0];
        res_carry = diff[WIDTH];
        res_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_AND:  res = bus.a & bus.b;
      ALU_OR:   res = bus.a | bus.b;
      ALU_XOR:  res = bus.a ^ bus.b;
      ALU_MUL:  res = '0;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      ALU_BZ:   res = {{(WIDTH-1){1'b0}}, bus.a == '0};
      ALU_SLTS: res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SHL:  res = bus.a << shamt;
      ALU_SHR:  res = bus.a >> shamt;
      ALU_SRA:  res = $signed(bus.a) >>> shamt;
      default:  res_err = 1'b1;
    endcase
  end

  // Result/flag registers: load on single-cycle accept or multiplier completion, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept && !is_mul) begin
      ans_q   <= res;
      zero_q  <= (res == '0);
      carry_q <= res_carry;
      ovf_q   <= res_ovf;
      neg_q   <= res[WIDTH-1];
      err_q   <= res_err;
    end else if (mul_done) begin
      ans_q   <= mul_prod[WIDTH-1:0];
      zero_q  <= (mul_prod[WIDTH-1:0] == '0);
      carry_q <= |mul_prod[2*WIDTH-1:WIDTH];
      ovf_q   <= 1'b0;
      neg_q   <= mul_prod[WIDTH-1];
      err_q   <= 1'b0;
    end
  end

  assign bus.ans   = ans_q;
  assign bus.zero  = zero_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.neg   = neg_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq at WIDTH=8: behavioural model + scoreboard, plus directed checks.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [12:0] exp_q[$];

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [12:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  alu_seq_if #(.WIDTH(8)) bus();

  alu_seq #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: {ans, zero, carry, ovf, neg, err} from plain integer arithmetic.
  function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, sh;
    bit c, v, e;
    logic [7:0] r8;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sh = ub % 8;
    c = 0; v = 0; e = 0; r = 0;
    case (op)
      4'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: begin r = ua * ub; c = (r > 255); end
      4'd6: r = (ua < ub) ? 1 : 0;
      4'd7: r = (ua == 0) ? 1 : 0;
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = ua << sh;
      4'd10: r = ua >> sh;
      4'd11: r = sa >>> sh;
      default: begin r = 0; e = 1; end
    endcase
    r8 = 8'(r & 255);
    return {r8, (r8 == 8'h00), c, v, r8[7], e};
  endfunction

  // Scoreboard: every cycle with a valid result, compare against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out_valid t=%0t: out_valid=1 with no op outstanding", $time);
        end else begin
          if ({bus.ans, bus.zero, bus.carry, bus.ovf, bus.neg, bus.err} !== exp_q[0]) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t: got {ans,z,c,v,n,e}=%h expected %h", $time,
                     {bus.ans, bus.zero, bus.carry, bus.ovf, bus.neg, bus.err}, exp_q[0]);
          end
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.op, bus.a, bus.b));
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int k;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int rdy);
    n = 0;
    rdy = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      n++;
      if (bus.in_ready) rdy++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rdy, seen;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = 4'h0;
    bus.a = 8'h00;
    bus.b = 8'h00;

    vecs.push_back('{"add_7f_01",  4'h0, 8'h7F, 8'h01, {8'h80, 5'b00110}, 0});
    vecs.push_back('{"sub_00_01",  4'h1, 8'h00, 8'h01, {8'hFF, 5'b01010}, 0});
    vecs.push_back('{"slts_ff_01", 4'h8, 8'hFF, 8'h01, {8'h01, 5'b00000}, 0});
    vecs.push_back('{"slt_ff_01",  4'h6, 8'hFF, 8'h01, {8'h00, 5'b10000}, 0});
    vecs.push_back('{"mul_10_10",  4'h5, 8'h10, 8'h10, {8'h00, 5'b11000}, 8});
    vecs.push_back('{"shl_81_3",   4'h9, 8'h81, 8'h03, {8'h08, 5'b00000}, 0});
    vecs.push_back('{"shr_81_3",   4'hA, 8'h81, 8'h03, {8'h10, 5'b00000}, 0});
    vecs.push_back('{"sra_81_b",   4'hB, 8'h81, 8'h0B, {8'hF0, 5'b00010}, 0});
    vecs.push_back('{"bz_00",      4'h7, 8'h00, 8'h55, {8'h01, 5'b00000}, 0});
    vecs.push_back('{"or_0f_30",   4'h3, 8'h0F, 8'h30, {8'h3F, 5'b00000}, 0});
    vecs.push_back('{"sub_80_01",  4'h1, 8'h80, 8'h01, {8'h7F, 5'b00100}, 0});
    vecs.push_back('{"add_ff_01",  4'h0, 8'hFF, 8'h01, {8'h00, 5'b11000}, 0});
    vecs.push_back('{"illegal_c",  4'hC, 8'h12, 8'h34, {8'h00, 5'b10001}, 0});
    vecs.push_back('{"mul_ff_ff",  4'h5, 8'hFF, 8'hFF, {8'h01, 5'b01000}, 8});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", {4'h0, bus.out_valid, bus.in_ready, bus.zero, bus.err, bus.ans},
          {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    check("reset_flags", {13'h0, bus.carry, bus.ovf, bus.neg}, 16'h0000);

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(n, rdy);
      check({"lat_", vecs[i].name}, 16'(n), 16'(vecs[i].lat));
      if (vecs[i].lat > 0) check({"busy_rdy_", vecs[i].name}, 16'(rdy), 16'h0000);
      check(vecs[i].name, {3'b000, bus.ans, bus.zero, bus.carry, bus.ovf, bus.neg, bus.err},
            {3'b000, vecs[i].exp});
    end

    // Backpressure: result must hold while the consumer stalls.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(4'h4, 8'hAA, 8'hFF);
    wait_valid(n, rdy);
    check("bp_lat", 16'(n), 16'h0000);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold", {6'h0, bus.out_valid, bus.in_ready, bus.ans}, {6'h0, 1'b1, 1'b0, 8'h55});
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {6'h0, bus.out_valid, bus.in_ready, bus.ans}, {6'h0, 1'b1, 1'b1, 8'h55});
    @(posedge clk);
    @(negedge clk);
    check("bp_drained", {15'h0, bus.out_valid}, 16'h0000);

    // Back-to-back: one result per cycle with both sides streaming.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = 4'h0; bus.a = 8'h01; bus.b = 8'h02;
    @(negedge clk);
    check("b2b_ready0", {15'h0, bus.in_ready}, 16'h0001);
    @(posedge clk); #1;
    bus.op = 4'h2; bus.a = 8'hF0; bus.b = 8'h3C;
    @(negedge clk);
    check("b2b_res0", {6'h0, bus.out_valid, bus.in_ready, bus.ans}, {6'h0, 1'b1, 1'b1, 8'h03});
    @(posedge clk); #1;
    bus.op = 4'hB; bus.a = 8'h80; bus.b = 8'h01;
    @(negedge clk);
    check("b2b_res1", {6'h0, bus.out_valid, bus.in_ready, bus.ans}, {6'h0, 1'b1, 1'b1, 8'h30});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_res2", {7'h0, bus.out_valid, bus.ans}, {7'h0, 1'b1, 8'hC0});

    // Reset in the middle of a multiply drops it completely.
    send(4'h5, 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_mul", {4'h0, bus.out_valid, bus.in_ready, bus.zero, bus.err, bus.ans},
          {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    check("rst_no_late_result", 16'(seen), 16'h0000);
    send(4'hD, 8'h12, 8'h34);
    wait_valid(n, rdy);
    check("illegal_d", {6'h0, bus.err, bus.zero, bus.ans}, {6'h0, 1'b1, 1'b1, 8'h00});

    @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
